bus_initiator: RTL

Bus master for the single-cycle-enable peripheral bus used by the GPIO block and its peers. The signals are address, data-to-slave, a 4-bit byte-select write (all zeros means read), enable, data-from-slave and ready.
- Accepts one request at a time from a client (CPU-side or debug bridge).
- Drives the access until the slave asserts ready, then returns read data.
- Reports a timeout error when the slave never acknowledges, for example on an unimplemented address.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_watchdog.sv | 37 +++
 rtl/bus_initiator.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the peripheral-bus initiator.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2
  } bus_state_e;

  localparam logic [3:0] BUS_WR_READ = 4'b0000;

  localparam int BUS_TIMEOUT_DEF = 16;
  localparam int BUS_RETRIES_DEF = 2;

  function automatic logic is_read(input logic [3:0] wr);
    return (wr == BUS_WR_READ);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Access watchdog: counts enable-high cycles, cleared at the start of each attempt,
// and flags the terminal count when TIMEOUT cycles have been spent waiting.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

  // saturate at terminal count so a stalled FSM never wraps back to zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_initiator.sv
// Single-request master for the enable/ready peripheral bus with timeout reporting.
// Optional retry-after-timeout is built when BUS_INITIATOR_RETRY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a client request, req_ready high
// ACCESS | bus_enable high, waiting for bus_ready or the watchdog
// GAP    | one enable-low cycle between timed-out attempts (retry build only)
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = BUS_TIMEOUT_DEF,
  parameter int RETRIES    = BUS_RETRIES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wr,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [31:0]           bus_data_o,
  output logic [3:0]            bus_wr,
  output logic                  bus_enable,
  input  logic [31:0]           bus_data_i,
  input  logic                  bus_ready
);

  if (TIMEOUT < 2 || RETRIES < 0) begin : g_bad_param
    $error("bus_initiator: TIMEOUT must be >= 2 and RETRIES >= 0");
  end

  bus_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wr_q, wr_d;
  logic                  en_q, en_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  wd_clr, wd_en, wd_tc;

`ifdef BUS_INITIATOR_RETRY_EN
  localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clr_i(wd_clr),
    .en_i (wd_en),
    .tc_o (wd_tc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    en_d        = en_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    req_ready   = 1'b0;
`ifdef BUS_INITIATOR_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wr_d    = req_wr;
          en_d    = 1'b1;
          wd_clr  = 1'b1;
`ifdef BUS_INITIATOR_RETRY_EN
          retry_d = '0;
`endif
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (bus_ready) begin
          rsp_rdata_d = is_read(wr_q) ? bus_data_i : 32'h0;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          en_d        = 1'b0;
          wr_d        = BUS_WR_READ;
          state_d     = ST_IDLE;
        end else if (wd_tc) begin
          en_d = 1'b0;
`ifdef BUS_INITIATOR_RETRY_EN
          if (retry_q == RW'(RETRIES)) begin
            rsp_rdata_d = 32'h0;
            rsp_error_d = 1'b1;
            rsp_valid_d = 1'b1;
            wr_d        = BUS_WR_READ;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
`else
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          wr_d        = BUS_WR_READ;
          state_d     = ST_IDLE;
`endif
        end else begin
          wd_en = 1'b1;
        end
      end

`ifdef BUS_INITIATOR_RETRY_EN
      // address, data and byte select are still held from the first attempt
      ST_GAP: begin
        en_d    = 1'b1;
        wd_clr  = 1'b1;
        retry_d = retry_q + 1'b1;
        state_d = ST_ACCESS;
      end
`endif

      default: begin
        en_d    = 1'b0;
        wr_d    = BUS_WR_READ;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= BUS_WR_READ;
      en_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      en_q        <= en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

`ifdef BUS_INITIATOR_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign bus_address = addr_q;
  assign bus_data_o  = wdata_q;
  assign bus_wr      = wr_q;
  assign bus_enable  = en_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;

endmodule
